regfile_2r1w: RTL and testbench
===============================

# regfile_2r1w

Parametrised register file: 2^ADDR_W registers of Q bits each, with two combinational read ports and one synchronous write port. Each read port is built as a Q-bit, 2^ADDR_W-to-1 selection; this generalises the fixed 32-input, 32-bit mux in width, depth and port count. The block sits between instruction decode (register addresses) and the ALU/writeback path of the lab CPU datapath.

## Interface
- Q, 32: data width in bits.
- ADDR_W, 5: address width. Depth is 2^ADDR_W, so every address is in range.
- ZERO_REG, 1: when 1, register 0 reads as 0 and ignores writes. When 0, register 0 is an ordinary register.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_ena  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  Q  write data.
- rd_addr0  input  ADDR_W  read port 0 address.
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_data0  output  Q  read port 0 data (combinational).
- rd_data1  output  Q  read port 1 data (combinational).

## Operation
- Storage: registers r[0 .. 2^ADDR_W-1], each Q bits.
- Write:
  - At a rising edge of clk with wr_ena=1 and rst=0, r[wr_addr] <= wr_data.
  - All other registers hold their value.
- Zero register:
  - With ZERO_REG=1, a write to address 0 is discarded.
  - With ZERO_REG=1, any read of address 0 returns 0 regardless of other inputs.
- Read:
  - rd_dataN = r[rd_addrN], purely combinational from the address and the stored state.
  - The two ports are fully independent. Both may read the same address.
- Reset:
  - rst=1 asynchronously clears every register to 0, immediately and without waiting for a clock edge.
  - While rst=1, writes are blocked.
  - Reset asserted at the same edge as a write: reset wins and the register is 0 afterwards.
  - Reset deasserted mid-cycle: the first write takes effect at the next rising edge with rst=0.
- Unknown inputs: wr_ena=X at an edge must not occur. The testbench does not drive it.

## Timing
- Output values during and immediately after reset: rd_data0 = rd_data1 = 0 for every address.
- Write latency: 1 cycle. Data written at edge k is visible on a read port after edge k, with no bypass (see Configuration).
- Read latency: 0 cycles (combinational). Address changes propagate within the same cycle.
- Read and write of the same address in the same cycle: without the bypass, the read returns the old value until the edge.
- Back-to-back writes to the same address: the last write wins. Each edge commits exactly one write.
- No handshake; wr_ena is a single-cycle strobe per write.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding on both read ports. If wr_ena=1, rst=0 and rd_addrN == wr_addr, then rd_dataN = wr_data combinationally in the same cycle.
  - With ZERO_REG=1, forwarding never applies to address 0; the read stays 0.
  - Storage update timing is unchanged.
- Undefined: no forwarding. Reads always reflect stored state, as described in Timing.

## Test plan
- Reset clear: write 0xDEADBEEF to r[5], then pulse rst for half a cycle with no clock edge. Read r[5] on both ports: 0x00000000 immediately.
- Write/read: write 0x12345678 to r[7] and 0xCAFEF00D to r[31]. Read rd_addr0=7, rd_addr1=31 -> 0x12345678 and 0xCAFEF00D on the cycle after the respective edges.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to address 0, then read address 0 on both ports -> 0. Repeat with ZERO_REG=0 -> 0xFFFFFFFF.
- Same-cycle read/write of r[3], old value 0x1, wr_data 0x2:
  - Without REGFILE_BYPASS_EN: rd_data0=0x1 before the edge and 0x2 after.
  - With REGFILE_BYPASS_EN: rd_data0=0x2 in the same cycle.
- Reset collides with a write: rst=1 at the same edge as a write of 0xAAAA5555 to r[9] -> r[9] reads 0 after the edge.
- Sweep: Q=8, ADDR_W=3. Write the value (addr*17) to every address, then read all addresses on both ports in opposite order. Every value must match, with no aliasing.

Source files
------------

// File: rtl/regfile_2r1w.sv
// Register file: 2^ADDR_W x Q bits, two combinational read ports, one synchronous write port.
// Optional write-through forwarding on both read ports when REGFILE_BYPASS_EN is defined.
module regfile_2r1w #(
  parameter int Q        = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_ena,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [Q-1:0]      wr_data,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [Q-1:0]      rd_data0,
  output logic [Q-1:0]      rd_data1
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][Q-1:0] regs;
  logic [DEPTH-1:0]        wr_sel;
  logic                    rd_zero0;
  logic                    rd_zero1;
  logic [Q-1:0]            mux0;
  logic [Q-1:0]            mux1;

  // One-hot write decode; register 0 never gets selected when it is hardwired to zero.
  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_ena && (wr_addr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0)))
        wr_sel[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_sel[i])
          regs[i] <= wr_data;
      end
    end
  end

  // Full DEPTH-to-1 selection per read port.
  always_comb begin
    mux0 = '0;
    mux1 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_addr0 == ADDR_W'(i))
        mux0 = regs[i];
      if (rd_addr1 == ADDR_W'(i))
        mux1 = regs[i];
    end
  end

  always_comb begin
    rd_zero0 = (ZERO_REG != 0) && (rd_addr0 == '0);
    rd_zero1 = (ZERO_REG != 0) && (rd_addr1 == '0);
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is gated by rst so reads stay 0 while reset is held.
  always_comb begin
    rd_data0 = mux0;
    rd_data1 = mux1;
    if (wr_ena && !rst && (rd_addr0 == wr_addr))
      rd_data0 = wr_data;
    if (wr_ena && !rst && (rd_addr1 == wr_addr))
      rd_data1 = wr_data;
    if (rd_zero0)
      rd_data0 = '0;
    if (rd_zero1)
      rd_data1 = '0;
  end
`else
  always_comb begin
    rd_data0 = rd_zero0 ? '0 : mux0;
    rd_data1 = rd_zero1 ? '0 : mux1;
  end
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w: default, ZERO_REG=0 and Q=8/ADDR_W=3 instances.
module tb_regfile_2r1w;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic [31:0] rd_data0;
  logic [31:0] rd_data1;
  logic [31:0] nz_data0;
  logic [31:0] nz_data1;

  logic        s_wr_ena;
  logic [2:0]  s_wr_addr;
  logic [7:0]  s_wr_data;
  logic [2:0]  s_rd_addr0;
  logic [2:0]  s_rd_addr1;
  logic [7:0]  s_rd_data0;
  logic [7:0]  s_rd_data1;

  int checks;
  int errors;

  regfile_2r1w #(.Q(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(rd_data0), .rd_data1(rd_data1)
  );

  regfile_2r1w #(.Q(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(nz_data0), .rd_data1(nz_data1)
  );

  regfile_2r1w #(.Q(8), .ADDR_W(3), .ZERO_REG(1)) dut_s (
    .clk(clk), .rst(rst), .wr_ena(s_wr_ena), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rd_addr0(s_rd_addr0), .rd_addr1(s_rd_addr1), .rd_data0(s_rd_data0), .rd_data1(s_rd_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr0 = 5'd0; rd_addr1 = 5'd31;
    s_wr_ena = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_rd_addr0 = '0; s_rd_addr1 = '0;

    @(posedge clk); #1;
    chk("reset_rd0", rd_data0, 32'h0);
    chk("reset_rd1", rd_data1, 32'h0);

    // write r5, then asynchronous reset pulse between edges
    @(negedge clk);
    rst = 1'b0;
    wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rd_addr0 = 5'd5; rd_addr1 = 5'd5;
    @(posedge clk); #1;
    wr_ena = 1'b0;
    chk("wr5_rd0", rd_data0, 32'hDEADBEEF);
    chk("wr5_rd1", rd_data1, 32'hDEADBEEF);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rd0", rd_data0, 32'h0);
    chk("async_rst_rd1", rd_data1, 32'h0);
    rst = 1'b0;
    #1;
    chk("after_rst_pulse", rd_data0, 32'h0);

    // independent ports, r7 and r31
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    rd_addr0 = 5'd7; rd_addr1 = 5'd31;
    @(posedge clk); #1;
    chk("wr7_rd0", rd_data0, 32'h12345678);
    chk("wr7_rd1_r31_empty", rd_data1, 32'h0);
    @(negedge clk);
    wr_addr = 5'd31; wr_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("wr31_rd0", rd_data0, 32'h12345678);
    chk("wr31_rd1", rd_data1, 32'hCAFEF00D);

    // zero register vs ordinary register 0
    @(negedge clk);
    wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    #1;
    chk("zero_same_cycle", rd_data0, 32'h0);
    chk("nz_same_cycle", nz_data0, BYP ? 32'hFFFFFFFF : 32'h0);
    @(posedge clk); #1;
    chk("zero_rd0", rd_data0, 32'h0);
    chk("zero_rd1", rd_data1, 32'h0);
    chk("nz_rd0", nz_data0, 32'hFFFFFFFF);
    chk("nz_rd1", nz_data1, 32'hFFFFFFFF);

    // same-cycle read/write of r3
    @(negedge clk);
    wr_addr = 5'd3; wr_data = 32'h1;
    rd_addr0 = 5'd3; rd_addr1 = 5'd7;
    @(posedge clk); #1;
    chk("r3_init", rd_data0, 32'h1);
    @(negedge clk);
    wr_data = 32'h2;
    #1;
    chk("r3_same_cycle", rd_data0, BYP ? 32'h2 : 32'h1);
    chk("r7_unaffected", rd_data1, 32'h12345678);
    @(posedge clk); #1;
    chk("r3_after_edge", rd_data0, 32'h2);

    // reset collides with a write to r9
    @(negedge clk);
    wr_addr = 5'd9; wr_data = 32'hAAAA5555;
    rd_addr0 = 5'd9; rd_addr1 = 5'd3;
    #4 rst = 1'b1;
    @(posedge clk); #1;
    chk("collide_r9", rd_data0, 32'h0);
    chk("collide_r3_cleared", rd_data1, 32'h0);
    @(negedge clk);
    wr_data = 32'h11;
    #1;
    chk("rst_held_no_fwd", rd_data0, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("rst_released_pre_edge", rd_data0, BYP ? 32'h11 : 32'h0);
    @(posedge clk); #1;
    chk("first_write_after_rst", rd_data0, 32'h11);

    // back-to-back writes to r12
    @(negedge clk);
    wr_addr = 5'd12; wr_data = 32'h100;
    rd_addr0 = 5'd12; rd_addr1 = 5'd9;
    @(posedge clk); #1;
    chk("b2b_first", rd_data0, 32'h100);
    @(negedge clk);
    wr_data = 32'h200;
    @(posedge clk); #1;
    chk("b2b_last", rd_data0, 32'h200);
    chk("b2b_r9_held", rd_data1, 32'h11);
    @(negedge clk);
    wr_ena = 1'b0;
    wr_data = 32'h300;
    @(posedge clk); #1;
    chk("no_write_when_disabled", rd_data0, 32'h200);

    // small-config sweep: addr*17 everywhere, read in opposite order
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      s_wr_ena = 1'b1;
      s_wr_addr = 3'(i);
      s_wr_data = 8'(i * 17);
    end
    @(negedge clk);
    s_wr_ena = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      s_rd_addr0 = 3'(i);
      s_rd_addr1 = 3'(7 - i);
      #1;
      chk($sformatf("sweep_rd0_a%0d", i), 32'(s_rd_data0), 32'(i * 17));
      chk($sformatf("sweep_rd1_a%0d", 7 - i), 32'(s_rd_data1), 32'((7 - i) * 17));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
